hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the pipeline's data-hazard forwarding logic. It tracks every in-flight register write in a DEPTH-stage shift scoreboard from EX through the last write-back stage. From that scoreboard it produces EX operand forward selects, an ID load-use stall, and a saturating stall counter. Producers carry a per-instruction result latency, so multi-cycle units (loads, future MUL) stall exactly as long as needed; ALU results forward with no stall.

## Interface
- NUM_REGS, 32: architectural register count; REG_AW = clog2(NUM_REGS).
- DEPTH, 3: scoreboard stages (index 0 = EX, 1 = MEM, 2 = WB); minimum 2.
- LAT_W, 2: width of the result-latency field.
- CNT_W, 16: stall counter width.
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  ID instruction advances into EX this cycle (ignored while stall=1).
- issue_we  in  1  instruction writes a register.
- issue_rd  in  REG_AW  destination register.
- issue_lat  in  LAT_W  stages after EX before the result exists (0 = ALU, 1 = load); values above DEPTH-2 are saturated to DEPTH-2.
- id_rs, id_rt  in  REG_AW  ID-stage source registers.
- id_rs_used, id_rt_used  in  1  source is actually read.
- stall  out  1  freeze IF/ID, inject bubble into EX.
- fwd_a, fwd_b  out  clog2(DEPTH)  EX operand source: 0 = register file, k = stage-k result bus.
- stall_cnt  out  CNT_W  stall cycles since reset, saturating.
- With HAZARD_BRFWD_EN only: id_is_branch  in  1; br_fwd_a, br_fwd_b  out  clog2(DEPTH).

## Operation
- Entry fields: valid, rd, lat. An entry is created only when issue_valid && issue_we && issue_rd != 0; register 0 never matches.
- Each clock: entry[k+1] <= entry[k] for k = 0..DEPTH-2; entry[DEPTH-1] retires.
  - When stall=0, entry[0] <= the issued instruction.
  - When stall=1, entry[0] <= bubble.
- ex_rs and ex_rt register id_rs and id_rt gated by the *_used flags and load with entry[0]; a bubble clears them to 0.
- Youngest-match rule: for a given source, only the lowest-index valid entry with rd == source is considered.
- fwd_a: youngest match of ex_rs among entries 1..DEPTH-1 at index k gives fwd_a = k; no match gives 0. fwd_b is the same using ex_rt.
- A matching entry at stage k is ready iff k >= lat + 1.
- stall: asserted when, for a used ID source, its youngest match among entries 0..DEPTH-2 is at index j with j < lat. After advancing, that producer would sit at j+1 and not yet be ready.
- stall_cnt increments on every stall=1 cycle and holds at 2^CNT_W-1.

## Timing
- fwd_a, fwd_b and stall are combinational from the current scoreboard and the ID inputs.
- Scoreboard, ex_rs/ex_rt and stall_cnt update on the rising clk edge.
- Reset values: all entries invalid; ex_rs = ex_rt = 0; fwd_a = fwd_b = 0; stall = 0; stall_cnt = 0.
- Reset is effective immediately, including mid-stall.
- ALU producer feeding the next instruction: 0 stall cycles. Load feeding the next instruction: 1 stall cycle.
- In general, stall lasts lat - j cycles for a producer currently at index j.
- Simultaneous issue and stall: the issue is ignored and a bubble is inserted.

## Configuration
- HAZARD_BRFWD_EN defined: branch operands compared in ID are forwarded.
  - br_fwd_a/b = k when the youngest match is at index k >= 1 and k >= lat + 1; otherwise 0.
  - stall additionally asserts when id_is_branch and the youngest match is at index 0, or at index k >= 1 with k < lat + 1.
- HAZARD_BRFWD_EN undefined: branch ports are absent and branches use only the normal stall rule.

## Structure
- hazard_pkg holds the scoreboard entry struct, forward-select encodings (FWD_RF = 0) and clog2 helper constants.
- One sub-module, hazard_match: a youngest-match priority finder returning hit, index and lat for one source register. It is instantiated per operand, i.e. 4 instances, or 6 with HAZARD_BRFWD_EN.

## Test plan
DEPTH = 3 in all scenarios.
- add r5 (lat 0), then sub with rs=r5 next cycle -> stall stays 0; the cycle sub is in EX, fwd_a = 1.
- lw r7 (lat 1), then add with rt=r7 -> stall = 1 for exactly one cycle, stall_cnt = 1; the add then reaches EX with fwd_b = 2.
- add r0 followed by a consumer of r0 -> fwd_a = 0 and stall = 0.
- add r3, then or r3, then and rs=r3 -> in EX, fwd_a = 1 (youngest), not 2.
- Load-use stall in progress, drive rst_n low mid-cycle -> stall = 0, fwd = 0 and stall_cnt = 0 immediately; no forwarding after release.
- With HAZARD_BRFWD_EN: beq rs=r3 in ID while add r3 is in EX -> stall = 1; next cycle br_fwd_a = 1 and stall = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: scoreboard entry type, forward-select encoding and select-width helper
package hazard_pkg;
  localparam int MAX_AW = 8;
  localparam int MAX_LAT_W = 4;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic                 valid;
    logic [MAX_AW-1:0]    rd;
    logic [MAX_LAT_W-1:0] lat;
  } sb_entry_t;
  function automatic int sel_w(int depth);
    return depth > 2 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: issue/ID-side inputs and stall/forward outputs of the hazard scoreboard
// master drives issue_* and id_* and reads stall, fwd_a/b, stall_cnt; slave is the scoreboard side.
// With HAZARD_BRFWD_EN the bundle also carries id_is_branch and br_fwd_a/b.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int DEPTH = 3,
  parameter int LAT_W = 2,
  parameter int CNT_W = 16
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int IW = hazard_pkg::sel_w(DEPTH);
  logic              issue_valid;
  logic              issue_we;
  logic [REG_AW-1:0] issue_rd;
  logic [LAT_W-1:0]  issue_lat;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              stall;
  logic [IW-1:0]     fwd_a;
  logic [IW-1:0]     fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
`ifdef HAZARD_BRFWD_EN
  logic              id_is_branch;
  logic [IW-1:0]     br_fwd_a;
  logic [IW-1:0]     br_fwd_b;
  modport master (output issue_valid, issue_we, issue_rd, issue_lat, id_rs, id_rt, id_rs_used, id_rt_used, id_is_branch,
                  input stall, fwd_a, fwd_b, stall_cnt, br_fwd_a, br_fwd_b);
  modport slave (input issue_valid, issue_we, issue_rd, issue_lat, id_rs, id_rt, id_rs_used, id_rt_used, id_is_branch,
                 output stall, fwd_a, fwd_b, stall_cnt, br_fwd_a, br_fwd_b);
`else
  modport master (output issue_valid, issue_we, issue_rd, issue_lat, id_rs, id_rt, id_rs_used, id_rt_used,
                  input stall, fwd_a, fwd_b, stall_cnt);
  modport slave (input issue_valid, issue_we, issue_rd, issue_lat, id_rs, id_rt, id_rs_used, id_rt_used,
                 output stall, fwd_a, fwd_b, stall_cnt);
`endif
endinterface

// File: rtl/hazard_match.sv
// hazard_match: youngest (lowest-index) valid scoreboard entry in [LO,HI] writing src_i
// Ports: src_i source register (0 never matches), sb_i scoreboard, hit_o/idx_o/lat_o of the match.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int LO = 0,
  parameter int HI = DEPTH - 1,
  parameter int IW = sel_w(DEPTH)
) (
  input  logic [MAX_AW-1:0]    src_i,
  input  sb_entry_t            sb_i [DEPTH],
  output logic                 hit_o,
  output logic [IW-1:0]        idx_o,
  output logic [MAX_LAT_W-1:0] lat_o
);
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    lat_o = '0;
    for (int k = HI; k >= LO; k--)
      if (sb_i[k].valid && sb_i[k].rd == src_i && src_i != '0) begin
        hit_o = 1'b1;
        idx_o = IW'(k);
        lat_o = sb_i[k].lat;
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write scoreboard driving EX forwarding, ID load-use stall and a saturating stall count
// Ports: clk, rst_n (asynchronous, active-low), bus (hazard_scoreboard_if.slave).
// Optional macro HAZARD_BRFWD_EN adds ID branch-operand forwarding and the matching branch stall.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DEPTH = 3,
  parameter int LAT_W = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int IW = sel_w(DEPTH);
`ifdef HAZARD_BRFWD_EN
  localparam int NM = 6;
`else
  localparam int NM = 4;
`endif
  sb_entry_t            sb_q [DEPTH];
  sb_entry_t            new_d;
  logic [REG_AW-1:0]    ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LAT_W-1:0]     lat_in;
  logic                 stall;
  logic [MAX_AW-1:0]    src [NM];
  logic                 m_hit [NM];
  logic [IW-1:0]        m_idx [NM];
  logic [MAX_LAT_W-1:0] m_lat [NM];
  // Finders 0/1: EX operands over stages 1..DEPTH-1; 2/3: ID stall check over 0..DEPTH-2; 4/5: ID branch over all stages.
  for (genvar i = 0; i < NM; i++) begin : g_m
    assign src[i] = MAX_AW'(i < 2 ? (i == 0 ? ex_rs_q : ex_rt_q) : (i % 2 == 0 ? bus.id_rs : bus.id_rt));
    hazard_match #(
      .DEPTH(DEPTH),
      .LO(i < 2 ? 1 : 0),
      .HI(i == 2 || i == 3 ? DEPTH - 2 : DEPTH - 1),
      .IW(IW)
    ) u_m (
      .src_i(src[i]),
      .sb_i(sb_q),
      .hit_o(m_hit[i]),
      .idx_o(m_idx[i]),
      .lat_o(m_lat[i])
    );
  end
  assign lat_in = bus.issue_lat;
  // A producer at stage j needs lat-j more cycles; branches compare in ID so they need one stage more.
  always_comb begin
    stall = (bus.id_rs_used && m_hit[2] && 32'(m_idx[2]) < 32'(m_lat[2])) ||
            (bus.id_rt_used && m_hit[3] && 32'(m_idx[3]) < 32'(m_lat[3]));
`ifdef HAZARD_BRFWD_EN
    stall = stall || (bus.id_is_branch &&
            ((bus.id_rs_used && m_hit[4] && 32'(m_idx[4]) <= 32'(m_lat[4])) ||
             (bus.id_rt_used && m_hit[5] && 32'(m_idx[5]) <= 32'(m_lat[5]))));
`endif
    new_d.valid = !stall && bus.issue_valid && bus.issue_we && bus.issue_rd != '0;
    new_d.rd = MAX_AW'(bus.issue_rd);
    new_d.lat = 32'(lat_in) > DEPTH - 2 ? MAX_LAT_W'(DEPTH - 2) : MAX_LAT_W'(lat_in);
    ex_rs_d = (!stall && bus.issue_valid && bus.id_rs_used) ? bus.id_rs : '0;
    ex_rt_d = (!stall && bus.issue_valid && bus.id_rt_used) ? bus.id_rt : '0;
    cnt_d = (stall && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sb_q[k] <= '0;
      ex_rs_q <= '0;
      ex_rt_q <= '0;
      cnt_q <= '0;
    end else begin
      sb_q[0] <= new_d;
      for (int k = 1; k < DEPTH; k++) sb_q[k] <= sb_q[k-1];
      ex_rs_q <= ex_rs_d;
      ex_rt_q <= ex_rt_d;
      cnt_q <= cnt_d;
    end
  assign bus.stall = stall;
  assign bus.fwd_a = m_hit[0] ? m_idx[0] : IW'(FWD_RF);
  assign bus.fwd_b = m_hit[1] ? m_idx[1] : IW'(FWD_RF);
  assign bus.stall_cnt = cnt_q;
`ifdef HAZARD_BRFWD_EN
  assign bus.br_fwd_a = (m_hit[4] && 32'(m_idx[4]) > 32'(m_lat[4])) ? m_idx[4] : IW'(FWD_RF);
  assign bus.br_fwd_b = (m_hit[5] && 32'(m_idx[5]) > 32'(m_lat[5])) ? m_idx[5] : IW'(FWD_RF);
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors against a producer-age model plus hand-computed expectations
module tb_hazard_scoreboard;
  localparam int D = 3;
  localparam int MAXC = 65535;
  logic clk = 0;
  logic rst_n = 1;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.DEPTH(D)) bus ();
  hazard_scoreboard #(.DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int pass = 0;
  int total = 0;
  bit run = 0;
  typedef struct { int rd; int lat; int t; } prod_t;
  prod_t q[$];
  int cyc = 0;
  int m_ex_rs = 0;
  int m_ex_rt = 0;
  int m_cnt = 0;
  typedef struct { bit v; bit we; int rd; int lat; int rs; int rt; bit rsu; bit rtu; } ins_t;
  ins_t vec [12] = '{
    '{1, 1, 12, 1, 1, 2, 1, 1},
    '{1, 1, 13, 0, 12, 12, 1, 1},
    '{1, 1, 13, 0, 12, 12, 1, 1},
    '{1, 1, 14, 2, 13, 0, 1, 0},
    '{1, 1, 15, 0, 14, 13, 1, 1},
    '{1, 1, 15, 0, 14, 13, 1, 1},
    '{1, 1, 0, 0, 15, 0, 1, 0},
    '{1, 1, 16, 0, 0, 15, 1, 1},
    '{1, 1, 16, 0, 16, 16, 1, 1},
    '{1, 0, 0, 0, 16, 14, 1, 1},
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{1, 1, 17, 0, 16, 17, 1, 0}
  };
  task automatic chk(string n, int a, int e);
    total++;
    if (a == e) pass++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask
  // Producer age is cycles since it entered EX; youngest = smallest age in [lo,hi].
  function automatic int young(int src, int lo, int hi, output int lat);
    int best;
    int s;
    best = -1;
    lat = 0;
    if (src == 0) return -1;
    foreach (q[i]) begin
      s = cyc - q[i].t;
      if (q[i].rd == src && s >= lo && s <= hi && (best < 0 || s < best)) begin
        best = s;
        lat = q[i].lat;
      end
    end
    return best;
  endfunction
  function automatic bit m_stall();
    int j;
    int l;
    bit s;
    s = 0;
    j = young(int'(bus.id_rs), 0, D - 2, l);
    if (bus.id_rs_used && j >= 0 && j < l) s = 1;
    j = young(int'(bus.id_rt), 0, D - 2, l);
    if (bus.id_rt_used && j >= 0 && j < l) s = 1;
`ifdef HAZARD_BRFWD_EN
    j = young(int'(bus.id_rs), 0, D - 1, l);
    if (bus.id_is_branch && bus.id_rs_used && j >= 0 && j <= l) s = 1;
    j = young(int'(bus.id_rt), 0, D - 1, l);
    if (bus.id_is_branch && bus.id_rt_used && j >= 0 && j <= l) s = 1;
`endif
    return s;
  endfunction
  function automatic int m_fwd(int src);
    int j;
    int l;
    j = young(src, 1, D - 1, l);
    return j < 0 ? 0 : j;
  endfunction
  function automatic int m_brfwd(int src);
    int j;
    int l;
    j = young(src, 0, D - 1, l);
    return (j >= 1 && j > l) ? j : 0;
  endfunction
  always @(posedge clk) begin
    bit st;
    bit go;
    if (rst_n) begin
      st = m_stall();
      go = !st && bus.issue_valid;
      if (st && m_cnt < MAXC) m_cnt++;
      m_ex_rs = (go && bus.id_rs_used) ? int'(bus.id_rs) : 0;
      m_ex_rt = (go && bus.id_rt_used) ? int'(bus.id_rt) : 0;
      cyc++;
      if (go && bus.issue_we && bus.issue_rd != 0)
        q.push_back('{int'(bus.issue_rd), int'(bus.issue_lat) > D - 2 ? D - 2 : int'(bus.issue_lat), cyc});
      while (q.size() > 0 && cyc - q[0].t >= D) void'(q.pop_front());
    end
  end
  always @(negedge rst_n) begin
    q.delete();
    m_ex_rs = 0;
    m_ex_rt = 0;
    m_cnt = 0;
  end
  always @(negedge clk)
    if (rst_n && run) begin
      chk("stall", int'(bus.stall), int'(m_stall()));
      chk("fwd_a", int'(bus.fwd_a), m_fwd(m_ex_rs));
      chk("fwd_b", int'(bus.fwd_b), m_fwd(m_ex_rt));
      chk("stall_cnt", int'(bus.stall_cnt), m_cnt);
`ifdef HAZARD_BRFWD_EN
      chk("br_fwd_a", int'(bus.br_fwd_a), m_brfwd(int'(bus.id_rs)));
      chk("br_fwd_b", int'(bus.br_fwd_b), m_brfwd(int'(bus.id_rt)));
`endif
    end
  task automatic set(bit v, bit we, int rd, int lat, int rs, int rt, bit rsu, bit rtu, bit br);
    bus.issue_valid = v;
    bus.issue_we = we;
    bus.issue_rd = 5'(rd);
    bus.issue_lat = 2'(lat);
    bus.id_rs = 5'(rs);
    bus.id_rt = 5'(rt);
    bus.id_rs_used = rsu;
    bus.id_rt_used = rtu;
`ifdef HAZARD_BRFWD_EN
    bus.id_is_branch = br;
`else
    if (br) $display("note: branch input unavailable in this build");
`endif
  endtask
  task automatic drive(bit v, bit we, int rd, int lat, int rs, int rt, bit rsu, bit rtu, bit br = 0);
    @(posedge clk);
    #1;
    set(v, we, rd, lat, rs, rt, rsu, rtu, br);
  endtask
  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic hold();
    @(posedge clk);
    #1;
  endtask
  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask
  initial begin
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_fwd_a", int'(bus.fwd_a), 0);
    chk("rst_cnt", int'(bus.stall_cnt), 0);
    rst_n = 1;
    run = 1;
    drive(1, 1, 5, 0, 1, 2, 1, 1);
    drive(1, 1, 6, 0, 5, 2, 1, 1);
    at_neg(); chk("alu_no_stall", int'(bus.stall), 0);
    nop();
    at_neg(); chk("alu_fwd_a", int'(bus.fwd_a), 1);
    drive(1, 1, 7, 1, 1, 0, 1, 0);
    drive(1, 1, 8, 0, 2, 7, 1, 1);
    at_neg(); chk("load_stall", int'(bus.stall), 1); chk("load_cnt0", int'(bus.stall_cnt), 0);
    hold();
    at_neg(); chk("load_release", int'(bus.stall), 0); chk("load_cnt1", int'(bus.stall_cnt), 1);
    nop();
    at_neg(); chk("load_fwd_b", int'(bus.fwd_b), 2);
    drive(1, 1, 0, 0, 1, 2, 1, 1);
    drive(1, 1, 9, 0, 0, 0, 1, 1);
    at_neg(); chk("r0_no_stall", int'(bus.stall), 0);
    nop();
    at_neg(); chk("r0_fwd_a", int'(bus.fwd_a), 0);
    drive(1, 1, 3, 0, 1, 2, 1, 1);
    drive(1, 1, 3, 0, 1, 2, 1, 1);
    drive(1, 1, 4, 0, 3, 0, 1, 0);
    at_neg(); chk("young_no_stall", int'(bus.stall), 0);
    nop();
    at_neg(); chk("young_fwd_a", int'(bus.fwd_a), 1);
    drive(1, 1, 10, 3, 1, 0, 1, 0);
    drive(1, 1, 11, 0, 10, 0, 1, 0);
    at_neg(); chk("sat_stall", int'(bus.stall), 1);
    hold();
    at_neg(); chk("sat_release", int'(bus.stall), 0); chk("sat_cnt", int'(bus.stall_cnt), 2);
    nop();
    at_neg(); chk("sat_fwd_a", int'(bus.fwd_a), 2);
    foreach (vec[i]) drive(vec[i].v, vec[i].we, vec[i].rd, vec[i].lat, vec[i].rs, vec[i].rt, vec[i].rsu, vec[i].rtu);
    nop();
    nop();
    drive(1, 1, 4, 0, 1, 0, 1, 0);
    drive(1, 1, 9, 1, 4, 0, 1, 0);
    drive(1, 1, 10, 0, 9, 0, 1, 0);
    at_neg(); chk("pre_rst_fwd_a", int'(bus.fwd_a), 1); chk("pre_rst_stall", int'(bus.stall), 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_stall", int'(bus.stall), 0);
    chk("mid_rst_fwd_a", int'(bus.fwd_a), 0);
    chk("mid_rst_cnt", int'(bus.stall_cnt), 0);
    @(posedge clk);
    #3 rst_n = 1;
    at_neg(); chk("post_rst_stall", int'(bus.stall), 0);
    nop();
    at_neg(); chk("post_rst_fwd_a", int'(bus.fwd_a), 0);
`ifdef HAZARD_BRFWD_EN
    drive(1, 1, 3, 0, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 3, 0, 1, 0, 1);
    at_neg(); chk("br_stall", int'(bus.stall), 1);
    hold();
    at_neg(); chk("br_release", int'(bus.stall), 0); chk("br_fwd_a_lit", int'(bus.br_fwd_a), 1);
    nop();
`endif
    nop();
    nop();
    run = 0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
